serial_cmp_ctrl: RTL

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

---
 rtl/serial_cmp_pkg.sv | 14 +
 rtl/bit_cmp_cell.sv | 16 +
 rtl/serial_cmp_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial comparator: FSM state encoding and default operand width.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package serial_cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit unsigned magnitude compare cell.
// Latency: purely combinational, no clock.
// Backpressure: none; the outputs follow the inputs directly.
module bit_cmp_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic lt,
    output logic gt
);

    assign eq = ~(a ^ b);
    assign lt = ~a & b;
    assign gt = a & ~b;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned comparator, MSB first; define SERIAL_CMP_EARLY_EXIT_EN to stop at the first differing bit.
// Latency: done pulses j+1 cycles after start is taken (j = bits examined); without early exit, always WIDTH+1.
// Backpressure: start is taken only in IDLE and is ignored while busy.
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;

    logic               bit_eq, bit_lt, bit_gt;

    bit_cmp_cell u_cell (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .eq (bit_eq),
        .lt (bit_lt),
        .gt (bit_gt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = IDX_W'(WIDTH - 1);
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                end
            end
            RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!bit_eq) begin
                    lt_d    = bit_lt;
                    gt_d    = bit_gt;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
`else
                // lt/gt double as the "already decided" flag so later bits cannot overwrite them
                if (!bit_eq && !(lt_q || gt_q)) begin
                    lt_d = bit_lt;
                    gt_d = bit_gt;
                end
                if (idx_q == '0) begin
                    eq_d    = bit_eq && !(lt_q || gt_q);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign lt   = lt_q;
    assign gt   = gt_q;

endmodule
